mmio_port_responder: RTL

Memory-mapped I/O responder on the processor's data-memory bus. It decodes a small register window, drives the 32-bit `PortOut` register, and samples the 8-bit `PortIn` pins through a synchronizer. It records rising edges in sticky status bits and queues every input change in a small FIFO. It sits beside the data memory and answers the processor's `MemRead`/`MemWrite` accesses; the top level muxes `ReadData` onto the load path when `Select` is high.

---
 rtl/mmio_port_responder_if.sv | 11 +
 rtl/mmio_port_responder.sv | 67 ++++++
 2 files changed

// File: rtl/mmio_port_responder_if.sv
// mmio_port_responder_if: data-memory bus signals shared by the processor and the port responder
interface mmio_port_responder_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic MemWrite;
  logic MemRead;
  logic Select;
  modport master(output Address, WriteData, MemWrite, MemRead, input ReadData, Select);
  modport slave(input Address, WriteData, MemWrite, MemRead, output ReadData, Select);
endinterface

// File: rtl/mmio_port_responder.sv
// mmio_port_responder: MMIO output port, synchronized input port, sticky edge status and input-change FIFO
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0100,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  mmio_port_responder_if.slave bus,
  input  logic [7:0] PortIn,
  output logic [31:0] PortOut,
  output logic EdgeIrq
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  logic [7:0] s1, s2, s3, edgeStatus, edgeMask;
  logic [7:0] fifoMem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] count;
  logic ovf, sel, wr, rd, pop, push, full, doPush, ovfSet;
  logic [4:0] off;
  assign off = bus.Address[4:0] & 5'h1C;
  assign sel = bus.Address[31:5] == BASE_ADDR[31:5];
  assign wr = bus.MemWrite && sel;
  assign rd = bus.MemRead && sel;
  assign pop = rd && off == 5'h10 && count != '0;
  assign push = s2 != s3;
  assign full = count == CW'(FIFO_DEPTH);
  // a pop on a full queue frees the slot the same-edge push lands in
  assign doPush = push && (!full || pop);
  assign ovfSet = push && full && !pop;
  assign bus.Select = sel;
  assign bus.ReadData = !sel ? 32'h0 :
    off == 5'h00 ? PortOut :
    off == 5'h04 ? {24'h0, s2} :
    off == 5'h08 ? {24'h0, edgeStatus} :
    off == 5'h0C ? {24'h0, edgeMask} :
    off == 5'h10 ? (count != '0 ? {24'h0, fifoMem[rdPtr]} : 32'h0) :
    off == 5'h14 ? {23'h0, ovf, 8'(count)} : 32'h0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      PortOut <= '0;
      edgeStatus <= '0;
      edgeMask <= '0;
      ovf <= 1'b0;
      EdgeIrq <= 1'b0;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      s1 <= PortIn;
      s2 <= s1;
      s3 <= s2;
      if (wr && off == 5'h00) PortOut <= bus.WriteData;
      if (wr && off == 5'h0C) edgeMask <= bus.WriteData[7:0];
      edgeStatus <= (edgeStatus & ~(wr && off == 5'h08 ? bus.WriteData[7:0] : 8'h0)) | (s2 & ~s3);
      ovf <= (ovf & ~(wr && off == 5'h14 && bus.WriteData[8])) | ovfSet;
      EdgeIrq <= |(edgeStatus & edgeMask);
      if (doPush) wrPtr <= wrPtr + PW'(1);
      if (pop) rdPtr <= rdPtr + PW'(1);
      count <= count + CW'(doPush) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (doPush) fifoMem[wrPtr] <= s2;
endmodule
